// File: rtl/fetch_frontend.sv
// fetch_frontend: in-order instruction fetch with prefetch queue, stall hold and redirect flush feeding IF/ID
module fetch_frontend #(
   parameter int unsigned     XLEN     = 32,
   parameter int unsigned     PC_STEP  = 1,
   parameter int unsigned     DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   output logic                       imem_req_valid_o,
   output logic [XLEN-1:0]            imem_req_addr_o,
   input  logic                       imem_req_ready_i,
   input  logic                       imem_rsp_valid_i,
   input  logic [31:0]                imem_rsp_data_i,
   input  logic                       redirect_i,
   input  logic [XLEN-1:0]            redirect_pc_i,
   input  logic                       stall_i,
   output logic                       ifid_valid_o,
   output logic [31:0]                ifid_ir_o,
   output logic [XLEN-1:0]            ifid_pc_o,
   output logic [$clog2(DEPTH):0]     q_count_o
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);
   typedef enum logic {FETCH, DRAIN} state_e;
   state_e state_q, state_d;
   logic go_q, fire, enq, deq;
   logic [CW-1:0] out_q, out_d, drop_q, drop_d, count_q;
   logic [AW-1:0] wr_q, rd_q;
   logic [XLEN-1:0] req_pc_q, rsp_pc_q, ifid_pc_q, ifid_pc_d;
   logic [31:0] ifid_ir_q, ifid_ir_d;
   logic ifid_valid_q, ifid_valid_d;
   logic [31:0] ir_mem [DEPTH];
   logic [XLEN-1:0] pc_mem [DEPTH];

   // go_q keeps the request port quiet for the first cycle after reset release
   assign imem_req_valid_o = go_q && state_q == FETCH && (out_q + count_q) < CW'(DEPTH);
   assign imem_req_addr_o  = req_pc_q;
   assign fire  = imem_req_valid_o && imem_req_ready_i;
   assign enq   = imem_rsp_valid_i && state_q == FETCH && !redirect_i;
   assign deq   = !redirect_i && !stall_i && count_q != '0;
   assign out_d = out_q + CW'(fire) - CW'(imem_rsp_valid_i);
   assign ifid_valid_o = ifid_valid_q;
   assign ifid_ir_o    = ifid_ir_q;
   assign ifid_pc_o    = ifid_pc_q;
   assign q_count_o    = count_q;

   // Next state, drop accounting and IF/ID next value (redirect > stall > advance)
   always_comb begin
      state_d      = state_q;
      drop_d       = drop_q;
      if (redirect_i) begin
         drop_d  = out_d;
         state_d = (out_d != '0) ? DRAIN : FETCH;
      end else if (state_q == DRAIN) begin
         drop_d  = drop_q - CW'(imem_rsp_valid_i);
         state_d = (drop_d == '0) ? FETCH : DRAIN;
      end
      ifid_valid_d = redirect_i ? 1'b0 : stall_i ? ifid_valid_q : deq;
      ifid_ir_d    = redirect_i ? NOP : stall_i ? ifid_ir_q : deq ? ir_mem[rd_q] : NOP;
      ifid_pc_d    = deq ? pc_mem[rd_q] : ifid_pc_q;
   end

   // Control state, PCs, queue pointers and IF/ID register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= FETCH;
         go_q         <= 1'b0;
         out_q        <= '0;
         drop_q       <= '0;
         count_q      <= '0;
         wr_q         <= '0;
         rd_q         <= '0;
         req_pc_q     <= RESET_PC;
         rsp_pc_q     <= RESET_PC;
         ifid_valid_q <= 1'b0;
         ifid_ir_q    <= NOP;
         ifid_pc_q    <= '0;
      end else begin
         state_q      <= state_d;
         go_q         <= 1'b1;
         out_q        <= out_d;
         drop_q       <= drop_d;
         count_q      <= redirect_i ? '0 : count_q + CW'(enq) - CW'(deq);
         wr_q         <= redirect_i ? '0 : wr_q + AW'(enq);
         rd_q         <= redirect_i ? '0 : rd_q + AW'(deq);
         req_pc_q     <= redirect_i ? redirect_pc_i : fire ? req_pc_q + STEP : req_pc_q;
         rsp_pc_q     <= redirect_i ? redirect_pc_i : enq ? rsp_pc_q + STEP : rsp_pc_q;
         ifid_valid_q <= ifid_valid_d;
         ifid_ir_q    <= ifid_ir_d;
         ifid_pc_q    <= ifid_pc_d;
      end
   end

   // Queue storage; no reset needed since occupancy gates every read
   always_ff @(posedge clk_i) begin
      if (enq) begin
         ir_mem[wr_q] <= imem_rsp_data_i;
         pc_mem[wr_q] <= rsp_pc_q;
      end
   end

   a_rsp_expected: assert property (@(posedge clk_i) disable iff (!rst_ni) imem_rsp_valid_i |-> out_q != '0);
endmodule
